// File: rtl/cordic_atan_lut.sv
// Arctangent ROM for the iterative CORDIC rotator: atan(2^-i) in Q2.16, plus registered copy and end-of-table flag.
// Optional sticky out-of-range flag enabled by defining LUT_RANGE_CHECK_EN.
module cordic_atan_lut #(
  parameter int IDX_W = 5,
  parameter int ANG_W = 18
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [IDX_W-1:0]        index,
  output logic signed [ANG_W-1:0] return_angle,
  output logic signed [ANG_W-1:0] angle_q,
  output logic                    last_q,
  output logic                    range_err
);

  localparam int TAB_N = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(16);
  localparam logic signed [ANG_W-1:0] ONE_LSB = ANG_W'(1);

  // Constants are Q2.16 (round(atan(2^-i) * 65536)); only ANG_W = 18 is meaningful.
  localparam logic signed [ANG_W-1:0] ATAN_TAB [0:TAB_N-1] = '{
    0:  ANG_W'(51472),
    1:  ANG_W'(30386),
    2:  ANG_W'(16055),
    3:  ANG_W'(8150),
    4:  ANG_W'(4091),
    5:  ANG_W'(2047),
    6:  ANG_W'(1024),
    7:  ANG_W'(512),
    8:  ANG_W'(256),
    9:  ANG_W'(128),
    10: ANG_W'(64),
    11: ANG_W'(32),
    12: ANG_W'(16),
    13: ANG_W'(8),
    14: ANG_W'(4),
    15: ANG_W'(2),
    16: ANG_W'(1),
    default: ANG_W'(0)
  };

  // Same-cycle read path into the CORDIC angle accumulator.
  always_comb begin
    return_angle = ATAN_TAB[index];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      angle_q <= '0;
      last_q  <= 1'b0;
    end else begin
      angle_q <= return_angle;
      last_q  <= (return_angle == ONE_LSB);
    end
  end

`ifdef LUT_RANGE_CHECK_EN
  // Sticky: any sample past the last non-zero entry is remembered until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      range_err <= 1'b0;
    end else if (index > LAST_IDX) begin
      range_err <= 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_atan_lut.sv
// Self-checking bench for cordic_atan_lut: table computed from atan(), per-cycle scoreboard, directed and random stimulus.
module tb_cordic_atan_lut;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [4:0]         index = '0;
  logic signed [17:0] return_angle;
  logic signed [17:0] angle_q;
  logic               last_q;
  logic               range_err;

  int tests = 0;
  int fails = 0;
  int tbl [32];
  int exp_angle = 0;
  bit exp_last = 1'b0;
  bit exp_rerr = 1'b0;
  bit started = 1'b0;

  always #5 clock = ~clock;

  cordic_atan_lut dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .index        (index),
    .return_angle (return_angle),
    .angle_q      (angle_q),
    .last_q       (last_q),
    .range_err    (range_err)
  );

  function automatic int ref_atan(int i);
    real v;
    v = $atan(2.0 ** (-i)) * 65536.0;
    return $rtoi(v + 0.5);
  endfunction

  task automatic check(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t idx=%0d)", name, act, expv, $time, index);
    end
  endtask

  // Reference registers: what the outputs must be after each edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_angle = 0;
      exp_last  = 1'b0;
      exp_rerr  = 1'b0;
    end else begin
      exp_angle = tbl[index];
      exp_last  = (tbl[index] == 1);
`ifdef LUT_RANGE_CHECK_EN
      if (index > 16) exp_rerr = 1'b1;
`endif
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("angle_q", angle_q, exp_angle);
      check("last_q", int'(last_q), int'(exp_last));
      check("range_err", int'(range_err), int'(exp_rerr));
      check("return_angle", return_angle, tbl[index]);
    end
  end

  initial begin
    int acc;
    int z;
    for (int i = 0; i < 32; i++) tbl[i] = ref_atan(i);
    started = 1'b1;

    // Combinational sweep while held in reset.
    for (int i = 0; i < 32; i++) begin
      @(posedge clock); #2 index = 5'(i);
      #1 check("sweep return_angle", return_angle, tbl[i]);
      $display("[TB] sweep idx=%0d return_angle=%0d angle_q=%0d", i, return_angle, angle_q);
    end
    #1 index = 5'd0;  #1 check("lit idx0", return_angle, 51472);
    #1 index = 5'd5;  #1 check("lit idx5", return_angle, 2047);
    #1 index = 5'd16; #1 check("lit idx16", return_angle, 1);
    #1 index = 5'd20; #1 check("lit idx20", return_angle, 0);
    check("reset angle_q", angle_q, 0);
    check("reset last_q", int'(last_q), 0);

    // Release and take one edge with index 0.
    @(posedge clock); #2 index = 5'd0; reset_n = 1'b1;
    @(posedge clock); #1 check("release angle_q", angle_q, 51472);

    // Step 0..16, one per clock.
    for (int i = 0; i <= 16; i++) begin
      @(posedge clock); #2 index = 5'(i);
      $display("[TB] step idx=%0d angle_q=%0d last_q=%0d", i, angle_q, last_q);
    end
    @(posedge clock); #1 check("last_q after 16", int'(last_q), 1);
    check("angle_q after 16", angle_q, 1);
    #1 index = 5'd4;
    @(posedge clock); #1 check("angle_q idx4", angle_q, 4091);
    check("last_q idx4", int'(last_q), 0);

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1 check("async angle_q", angle_q, 0);
    check("async last_q", int'(last_q), 0);
    check("async return_angle", return_angle, 4091);
    @(negedge clock); #1 reset_n = 1'b1;

    // Range flag: 17 then 3.
    @(posedge clock); #2 index = 5'd17;
    @(posedge clock); #2 index = 5'd3;
    @(posedge clock); #1;
`ifdef LUT_RANGE_CHECK_EN
    check("range_err sticky", int'(range_err), 1);
`else
    check("range_err tied", int'(range_err), 0);
`endif
    $display("[TB] range idx=17,3 range_err=%0d", range_err);

    // Random indices with occasional mid-cycle reset pulses.
    repeat (400) begin
      @(posedge clock); #2 index = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) begin
        #1 reset_n = 1'b0;
        #1 check("random async angle_q", angle_q, 0);
        check("random async range_err", int'(range_err), 0);
        reset_n = 1'b1;
      end
      $display("[TB] rand idx=%0d return_angle=%0d angle_q=%0d last_q=%0d range_err=%0d",
               index, return_angle, angle_q, last_q, range_err);
    end

    // CORDIC angle convergence to 0.5 rad using the live table.
    acc = 0;
    z = 32768;
    for (int i = 0; i <= 16; i++) begin
      @(posedge clock); #2 index = 5'(i);
      #1;
      if (z >= 0) begin
        acc += int'(return_angle);
        z   -= int'(return_angle);
      end else begin
        acc -= int'(return_angle);
        z   += int'(return_angle);
      end
      $display("[TB] cordic i=%0d acc=%0d residual=%0d", i, acc, z);
    end
    check("cordic within 17 LSB", int'((acc - 32768 <= 17) && (32768 - acc <= 17)), 1);

    @(posedge clock); @(negedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
